mem_wb_master: RTL
==================

// Module: mem_wb_master
// PURPOSE
//  Parametrised bridge from the PicoRV32 native memory port (valid/ready) to a Wishbone B4 classic master.
//  Sits between the core and the SoC interconnect.
//  Generalises the fixed 32-bit bridge with:
//  - configurable widths;
//  - full-word select on reads;
//  - ERR/RTY termination and a bounded retry loop;
//  - a watchdog timeout;
//  - a sticky bus-error report with the captured faulting address.
// PARAMETERS
//  ADDR_W      32           address width (mem and wbm)
//  DATA_W      32           data width; multiple of 8; SEL_W = DATA_W/8
//  TIMEOUT     255          max cycles waiting for ack/err/rty; 0 = watchdog disabled
//  MAX_RETRY   3            RTY reissues before treated as error; 0 = RTY is an error
//  RETRY_GAP   2            idle cycles (cyc=0) between RTY and reissue, >=1
//  ERR_RDATA   32'hDEADBEEF read data returned on error/timeout (DATA_W wide)
// PORTS
//  wb_clk_i      in  1       clock
//  wb_rst_ni     in  1       async active-low reset
//  mem_valid_i   in  1       core request valid
//  mem_instr_i   in  1       request is instruction fetch (captured for error report)
//  mem_addr_i    in  ADDR_W  request byte address
//  mem_wdata_i   in  DATA_W  write data
//  mem_wstrb_i   in  SEL_W   byte strobes; all-zero = read
//  mem_ready_o   out 1       one-cycle completion pulse
//  mem_rdata_o   out DATA_W  read data, valid while mem_ready_o=1
//  wbm_adr_o     out ADDR_W  WB address
//  wbm_dat_o     out DATA_W  WB write data
//  wbm_dat_i     in  DATA_W  WB read data
//  wbm_we_o      out 1       WB write enable
//  wbm_sel_o     out SEL_W   WB byte select
//  wbm_stb_o     out 1       WB strobe
//  wbm_cyc_o     out 1       WB cycle
//  wbm_ack_i     in  1       WB normal termination
//  wbm_err_i     in  1       WB error termination
//  wbm_rty_i     in  1       WB retry termination
//  bus_err_o     out 1       sticky: a transaction ended in error/timeout
//  err_addr_o    out ADDR_W  address of first unreported error
//  err_instr_o   out 1       that error was an instruction fetch
//  err_clr_i     in  1       clears bus_err_o (single-cycle pulse)
// BEHAVIOUR
//  Reset (async, wb_rst_ni=0): all outputs 0, state IDLE, counters 0; cyc/stb drop immediately mid-cycle.
//  States:
//   IDLE:  mem_valid_i=1 -> latch adr/dat/we/sel (from mem_*_i); set cyc=stb=1 -> REQ.
//          Read (wstrb==0): sel = all ones, we = 0. Write: sel = wstrb, we = 1.
//   REQ:   termination priority per cycle: err > ack > rty > timeout.
//          err                                           -> error path.
//          ack                                           -> rdata <= wbm_dat_i; cyc=stb=we=0 -> RESP.
//          rty and retry_cnt<MAX_RETRY                    -> cyc=stb=0; retry_cnt++ -> BACKOFF.
//          rty and retry_cnt==MAX_RETRY                   -> error path.
//          TIMEOUT!=0 and wait_cnt==TIMEOUT-1 and no term -> error path.
//          wait_cnt resets on each entry to REQ.
//   BACKOFF: RETRY_GAP cycles with cyc=0, then cyc=stb=1 with the same latched request -> REQ.
//   RESP:  mem_ready_o=1 for exactly this cycle -> IDLE; retry_cnt cleared.
//  Error path: rdata <= ERR_RDATA; cyc=stb=we=0; -> RESP.
//   - If bus_err_o==0: capture err_addr_o / err_instr_o and set bus_err_o.
//   - Later errors do not overwrite the capture.
//  Latency: valid seen at edge N -> cyc/stb from N+1; ack at edge M -> mem_ready_o in cycle M+1.
//   Zero-wait slave: 3 cycles per access.
//  Inputs ignored outside REQ: mem_valid_i in REQ/BACKOFF/RESP, and wbm_ack/err/rty_i outside REQ.
//  mem_valid_i must hold until ready (core contract); the request is not re-sampled.
//  err_clr_i the same cycle a new error sets: set wins (error not lost).
//  Counter widths: $clog2(TIMEOUT+1) and $clog2(MAX_RETRY+1), no wrap.
// STRUCTURE
//  Package mem_wb_pkg: state_e {IDLE,REQ,BACKOFF,RESP}; function sel_for(wstrb).
//  Sub-module wb_watchdog (load/tick/expire counter) instanced for TIMEOUT; GAP counter inline.
// TESTING
//  1. Read 0x0000_1000, slave acks with 0xCAFEF00D after 2 waits.
//     -> sel=4'hF, we=0; mem_ready 1 cycle, rdata=0xCAFEF00D; cyc low after ack.
//  2. Write 0x20 strb 4'b0110 data 0x11223344, zero-wait ack.
//     -> adr=0x20, sel=4'b0110, we=1; ready 3 cycles after valid.
//  3. Slave rty twice then acks, MAX_RETRY=3, RETRY_GAP=2.
//     -> two cyc gaps of 2 cycles; success; bus_err_o stays 0.
//  4. No slave response, TIMEOUT=8.
//     -> ready after 8 wait cycles, rdata=0xDEADBEEF; bus_err_o=1; err_addr=req addr; err_instr as driven.
//  5. err and ack same cycle on fetch 0x400 -> error path taken; err_instr_o=1.
//     Second error at 0x500 -> err_addr stays 0x400.
//     err_clr_i -> bus_err_o=0.
//  6. wb_rst_ni low mid-REQ -> cyc/stb/ready 0 asynchronously.
//     After release: IDLE; next request completes normally.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types and helpers for the PicoRV32-native to Wishbone B4 classic bridge.
//   state_e : bridge FSM states
//   sel_for : byte-select for a request (all lanes on reads, the strobes on writes)
package mem_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_e;

    // sel_for works on a fixed-width carrier so one function serves every
    // DATA_W up to 512 bits; callers zero-extend in and size-cast out.
    localparam int SEL_MAX = 64;

    function automatic logic [SEL_MAX-1:0] sel_for(input logic [SEL_MAX-1:0] wstrb,
                                                   input int                 sel_w);
        logic [SEL_MAX-1:0] all_lanes;
        all_lanes = (sel_w >= SEL_MAX) ? '1 : ((SEL_MAX'(1) << sel_w) - SEL_MAX'(1));
        return (wstrb == '0) ? all_lanes : wstrb;
    endfunction

endpackage

// File: rtl/mem_wb_master_watchdog.sv
// Watchdog counter for a Wishbone bus cycle that may never be terminated.
//   clk, rst_n : clock, async active-low reset
//   load       : restart the count at zero (on every entry into the wait state)
//   tick       : one cycle spent waiting for a termination
//   expire     : this is the TIMEOUT-th waiting cycle; never set when TIMEOUT = 0
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic expire
);

    localparam int               CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LAST)) begin
            // Saturates at LAST: the count never wraps.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/mem_wb_master.sv
// Bridge from the PicoRV32 native memory port (valid/ready) to a Wishbone B4
// classic master, with ERR/RTY handling, bounded retries, a watchdog and a
// sticky bus-error report.
//   wb_clk_i, wb_rst_ni          : clock, async active-low reset
//   mem_valid_i .. mem_wstrb_i   : core request (wstrb all-zero = read)
//   mem_ready_o, mem_rdata_o     : one-cycle completion pulse and read data
//   wbm_*                        : Wishbone classic master port
//   bus_err_o, err_addr_o,
//   err_instr_o, err_clr_i       : sticky error flag, captured faulting request, clear
module mem_wb_master
    import mem_wb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT   = 255,
    parameter int                MAX_RETRY = 3,
    parameter int                RETRY_GAP = 2,
    parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  mem_valid_i,
    input  logic                  mem_instr_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [DATA_W/8-1:0]   mem_wstrb_i,
    output logic                  mem_ready_o,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  wbm_rty_i,
    output logic                  bus_err_o,
    output logic [ADDR_W-1:0]     err_addr_o,
    output logic                  err_instr_o,
    input  logic                  err_clr_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int RC_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = $clog2(RETRY_GAP + 1);

    localparam logic [RC_W-1:0]  RETRY_LIMIT = RC_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(RETRY_GAP - 1);

    state_e              state_q,     state_d;
    logic                cyc_q,       cyc_d;
    logic                stb_q,       stb_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   adr_q,       adr_d;
    logic [DATA_W-1:0]   dat_q,       dat_d;
    logic [SEL_W-1:0]    sel_q,       sel_d;
    logic                instr_q,     instr_d;
    logic                ready_q,     ready_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic [RC_W-1:0]     retry_cnt_q, retry_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q,   gap_cnt_d;
    logic                bus_err_q,   bus_err_d;
    logic [ADDR_W-1:0]   err_addr_q,  err_addr_d;
    logic                err_instr_q, err_instr_d;

    logic wd_load, wd_tick, wd_expire;
    logic take_err;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .load   (wd_load),
        .tick   (wd_tick),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        instr_d     = instr_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        retry_cnt_d = retry_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        bus_err_d   = bus_err_q;
        err_addr_d  = err_addr_q;
        err_instr_d = err_instr_q;
        wd_load     = 1'b0;
        wd_tick     = 1'b0;
        take_err    = 1'b0;

        // A clear is applied first so an error terminating this same cycle
        // re-sets the flag below and is not lost.
        if (err_clr_i) begin
            bus_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    adr_d   = mem_addr_i;
                    dat_d   = mem_wdata_i;
                    we_d    = |mem_wstrb_i;
                    sel_d   = SEL_W'(sel_for(SEL_MAX'(mem_wstrb_i), SEL_W));
                    instr_d = mem_instr_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    wd_load = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                wd_tick = 1'b1;
                // Termination priority: err > ack > rty > watchdog.
                if (wbm_err_i) begin
                    take_err = 1'b1;
                end else if (wbm_ack_i) begin
                    rdata_d = wbm_dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (wbm_rty_i) begin
                    if (retry_cnt_q < RETRY_LIMIT) begin
                        // we/adr/sel/dat are kept for the reissue.
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        retry_cnt_d = retry_cnt_q + RC_W'(1);
                        gap_cnt_d   = '0;
                        state_d     = BACKOFF;
                    end else begin
                        take_err = 1'b1;
                    end
                end else if (wd_expire) begin
                    take_err = 1'b1;
                end
            end

            BACKOFF: begin
                if (gap_cnt_q == GAP_LAST) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    wd_load = 1'b1;
                    state_d = REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            RESP: begin
                retry_cnt_d = '0;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (take_err) begin
            rdata_d   = ERR_RDATA;
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            we_d      = 1'b0;
            ready_d   = 1'b1;
            state_d   = RESP;
            bus_err_d = 1'b1;
            // Only the first unreported error is captured.
            if (!bus_err_q) begin
                err_addr_d  = adr_q;
                err_instr_d = instr_q;
            end
        end
    end

    // NOTE: every flop here, including the latched request and the error
    // capture, is reset so all outputs are defined (and cyc/stb drop) the
    // moment wb_rst_ni falls, without waiting for a clock.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            instr_q     <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            retry_cnt_q <= '0;
            gap_cnt_q   <= '0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_instr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            instr_q     <= instr_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            retry_cnt_q <= retry_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            err_instr_q <= err_instr_d;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_cyc_o   = cyc_q;
    assign bus_err_o   = bus_err_q;
    assign err_addr_o  = err_addr_q;
    assign err_instr_o = err_instr_q;

endmodule
